// File: rtl/text_terminal.sv
// text_terminal: character-cell terminal core.
// Takes a byte stream, keeps a COLS x ROWS text framebuffer with a cursor and
// serves glyph codes to the pixel pipeline by screen coordinate. Overflowing
// the screen (by text or by carriage return on the last row) sweeps the whole
// framebuffer back to spaces and homes the cursor.
// Optional feature macro: TERM_CURSOR_BLINK_EN (cursor blink writes).
module text_terminal #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int BLINK_BITS = 23
) (
  input  logic       clk_25mhz,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [7:0] glyph,
  output logic [6:0] cur_col,
  output logic [4:0] cur_row,
  output logic       clearing
);

  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [6:0]       col_q, col_d;
  logic [4:0]       row_q, row_d;
  logic [7:0]       glyph_q;
  logic [7:0]       fb_q [CELLS];

  logic [IDX_W-1:0] cur_idx_s;
  logic [15:0]      rd_idx_s;
  logic             accept_s;
  logic             is_cr_s;
  logic             is_lf_s;
  logic             char_wr_s;
  logic             we_s;
  logic [IDX_W-1:0] wa_s;
  logic [7:0]       wd_s;
  logic             blink_fire_s;
  logic [7:0]       blink_char_s;

  assign cur_idx_s = IDX_W'(32'(row_q) * COLS + 32'(col_q));
  assign rd_idx_s  = 16'(32'(pix_y >> 4) * COLS + 32'(pix_x >> 3));
  assign accept_s  = (state_q == ST_IDLE) && in_valid;
  assign is_cr_s   = (in_data == 8'h0D);
  assign is_lf_s   = (in_data == 8'h0A);
  assign char_wr_s = accept_s && !is_cr_s && !is_lf_s;

`ifdef TERM_CURSOR_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt_q;
  logic                  phase_q;

  // Blink events fire on counter wrap, but only when the write port is free.
  assign blink_fire_s = (&blink_cnt_q) && (state_q == ST_IDLE) && !char_wr_s;
  assign blink_char_s = phase_q ? 8'h20 : 8'h5F;

  // Free-running blink counter and blink phase, toggled only on a fired event.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      phase_q     <= phase_q ^ blink_fire_s;
    end
  end
`else
  logic unused_blink_cfg_s;

  assign blink_fire_s       = 1'b0;
  assign blink_char_s       = 8'h20;
  assign unused_blink_cfg_s = (BLINK_BITS > 0);
`endif

  // Next-state, cursor motion and single write-port arbitration.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    col_d     = col_q;
    row_d     = row_q;
    we_s      = 1'b0;
    wa_s      = cur_idx_s;
    wd_s      = in_data;
    case (state_q)
      ST_CLEAR: begin
        we_s = 1'b1;
        wa_s = clr_idx_q;
        wd_s = 8'h20;
        if (clr_idx_q == IDX_W'(CELLS - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
          col_d     = 7'd0;
          row_d     = 5'd0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // Write port: accepted character wins, otherwise a blink may use it.
        if (char_wr_s) begin
          we_s = 1'b1;
          wd_s = in_data;
        end else if (blink_fire_s) begin
          we_s = 1'b1;
          wd_s = blink_char_s;
        end else begin
          we_s = 1'b0;
        end
        // Cursor motion for the accepted byte.
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (is_cr_s) begin
          if (row_q == 5'(ROWS - 1)) begin
            state_d = ST_CLEAR;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else if (is_lf_s) begin
          col_d = 7'd0;
        end else if (col_q == 7'(COLS - 1)) begin
          col_d = 7'd0;
          if (row_q == 5'(ROWS - 1)) begin
            state_d = ST_CLEAR;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Control state, sweep index and cursor registers.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      col_q     <= 7'd0;
      row_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  // Framebuffer write port; contents are initialised by the sweep, not reset.
  always_ff @(posedge clk_25mhz) begin
    if (we_s) begin
      fb_q[wa_s] <= wd_s;
    end
  end

  // Registered glyph read; coordinates past the last cell read as a space.
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      glyph_q <= 8'h20;
    end else if (rd_idx_s < 16'(CELLS)) begin
      glyph_q <= fb_q[rd_idx_s[IDX_W-1:0]];
    end else begin
      glyph_q <= 8'h20;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign clearing = (state_q == ST_CLEAR);
  assign cur_col  = col_q;
  assign cur_row  = row_q;
  assign glyph    = glyph_q;

endmodule

// File: tb/tb_text_terminal.sv
// Self-checking bench for text_terminal: a behavioural screen model predicts
// every cycle; glyph expectations go through a scoreboard queue.
module tb_text_terminal;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int BB    = 4;

  logic       clk_25mhz = 1'b0;
  logic       resetn    = 1'b1;
  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [9:0] pix_x     = 10'd0;
  logic [9:0] pix_y     = 10'd0;
  logic [7:0] glyph;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic       clearing;

  always #20 clk_25mhz = ~clk_25mhz;

  text_terminal #(.COLS(COLS), .ROWS(ROWS), .BLINK_BITS(BB)) dut (
    .clk_25mhz(clk_25mhz),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .glyph    (glyph),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .clearing (clearing)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] fb_m  [CELLS];
  int         m_col, m_row, m_ci;
  bit         m_clear;
`ifdef TERM_CURSOR_BLINK_EN
  int         m_bcnt;
  bit         m_phase;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply what the coming clock edge should do to the model.
  task automatic model_edge();
    bit acc, cw;
    acc = !m_clear && in_valid;
    cw  = acc && (in_data != 8'h0D) && (in_data != 8'h0A);
`ifdef TERM_CURSOR_BLINK_EN
    if (!m_clear && !cw && m_bcnt == (1 << BB) - 1) begin
      fb_m[m_row * COLS + m_col] = m_phase ? 8'h20 : 8'h5F;
      m_phase = !m_phase;
    end
    m_bcnt = (m_bcnt + 1) % (1 << BB);
`endif
    if (m_clear) begin
      fb_m[m_ci] = 8'h20;
      if (m_ci == CELLS - 1) begin
        m_clear = 1'b0;
        m_ci    = 0;
        m_col   = 0;
        m_row   = 0;
      end else begin
        m_ci++;
      end
    end else if (acc) begin
      if (in_data == 8'h0D) begin
        if (m_row == ROWS - 1) m_clear = 1'b1;
        else m_row++;
      end else if (in_data == 8'h0A) begin
        m_col = 0;
      end else begin
        fb_m[m_row * COLS + m_col] = in_data;
        if (m_col == COLS - 1) begin
          m_col = 0;
          if (m_row == ROWS - 1) m_clear = 1'b1;
          else m_row++;
        end else begin
          m_col++;
        end
      end
    end
  endtask

  // One clock: predict, advance, then compare control outputs (and glyph if asked).
  task automatic tick(input bit chk);
    int idx;
    logic [7:0] e;
    idx = (int'(pix_y) >> 4) * COLS + (int'(pix_x) >> 3);
    e   = (idx < CELLS) ? fb_m[idx] : 8'h20;
    model_edge();
    if (chk) exp_q.push_back(e);
    @(posedge clk_25mhz);
    #1;
    check("in_ready", in_ready, {31'd0, !m_clear});
    check("clearing", clearing, {31'd0, m_clear});
    if (!m_clear) begin
      check("cur_col", cur_col, m_col);
      check("cur_row", cur_row, m_row);
    end
    if (chk) check("glyph", glyph, exp_q.pop_front());
  endtask

  task automatic set_pix(input int idx);
    pix_x = 10'((idx % COLS) * 8 + (idx % 8));
    pix_y = 10'((idx / COLS) * 16 + (idx % 16));
  endtask

  task automatic send(input logic [7:0] b, input bit chk);
    in_data  = b;
    in_valid = 1'b1;
    tick(chk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_25mhz);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_clearing", clearing, 1);
    check("rst_cur_col", cur_col, 0);
    check("rst_cur_row", cur_row, 0);
    check("rst_glyph", glyph, 32'h20);
    repeat (3) @(posedge clk_25mhz);
    #1;
    resetn  = 1'b1;
    m_clear = 1'b1;
    m_ci    = 0;
    m_col   = 0;
    m_row   = 0;
`ifdef TERM_CURSOR_BLINK_EN
    m_bcnt  = 0;
    m_phase = 1'b0;
`endif
    exp_q.delete();
  endtask

  task automatic wait_clear_done();
    int n;
    n = 0;
    while (!in_ready && n < 3000) begin
      tick(1'b0);
      n++;
    end
    check("clear_cycles", n, CELLS);
  endtask

  task automatic read_all();
    for (int i = 0; i < CELLS; i++) begin
      set_pix(i);
      tick(1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < CELLS; i++) fb_m[i] = 8'h20;

    // Reset, sweep length, blank screen.
    do_reset();
    check("post_rel_in_ready", in_ready, 0);
    wait_clear_done();
    check("home_col", cur_col, 0);
    check("home_row", cur_row, 0);
    read_all();

    // Fill all but the last cell, then probe contents and out-of-range reads.
    for (int i = 0; i < CELLS - 1; i++) send(8'(8'h21 + i % 90), 1'b0);
    check("fill_col", cur_col, COLS - 1);
    check("fill_row", cur_row, ROWS - 1);
    set_pix(0);    tick(1'b1);
    set_pix(1234); tick(1'b1);
    set_pix(2398); tick(1'b1);
    pix_x = 10'd640;  pix_y = 10'd0;    tick(1'b1);
    pix_x = 10'd0;    pix_y = 10'd480;  tick(1'b1);
    pix_x = 10'd1023; pix_y = 10'd1023; tick(1'b1);

    // Last cell overflows the screen: full sweep, home, blank.
    send(8'h7E, 1'b0);
    check("ovf_clearing", clearing, 1);
    check("ovf_in_ready", in_ready, 0);
    wait_clear_done();
    check("ovf_home_col", cur_col, 0);
    check("ovf_home_row", cur_row, 0);
    read_all();

    // 'A' while reading cell 0 sees old contents; then 'B'.
    set_pix(0);
    send(8'h41, 1'b1);
    send(8'h42, 1'b0);
    check("ab_col", cur_col, 2);
    pix_x = 10'd8; pix_y = 10'd0; tick(1'b1);
    check("glyph_8_0", glyph, 32'h42);
    set_pix(0); tick(1'b1);

    // CR, LF, 'C' lands at cell 80.
    send(8'h0D, 1'b0);
    send(8'h0A, 1'b0);
    send(8'h43, 1'b0);
    check("crlf_col", cur_col, 1);
    check("crlf_row", cur_row, 1);
    set_pix(80); tick(1'b1);
    set_pix(1);  tick(1'b1);

    // CR down to the last row, then one more triggers the sweep.
    for (int i = 0; i < ROWS - 2; i++) send(8'h0D, 1'b0);
    check("cr_row_last", cur_row, ROWS - 1);
    check("cr_col_kept", cur_col, 1);
    send(8'h0D, 1'b0);
    check("cr_ovf_clearing", clearing, 1);

    // Reset part way through the sweep while cell 80 still holds 'C'.
    for (int i = 0; i < 40; i++) tick(1'b0);
    set_pix(80); tick(1'b1);
    check("mid_glyph_c", glyph, 32'h43);
    do_reset();
    wait_clear_done();
    read_all();

`ifdef TERM_CURSOR_BLINK_EN
    // Idle blinking of the cursor cell, then a byte accepted on a blink cycle.
    send(8'h0D, 1'b0);
    send(8'h44, 1'b0);
    for (int i = 0; i < 48; i++) begin
      set_pix(m_row * COLS + m_col);
      tick(1'b1);
    end
    for (int k = 0; k < 32 && m_bcnt != (1 << BB) - 1; k++) tick(1'b0);
    send(8'h5A, 1'b0);
    set_pix(m_row * COLS + m_col - 1); tick(1'b1);
    for (int i = 0; i < 40; i++) begin
      set_pix(m_row * COLS + m_col);
      tick(1'b1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
